interval_timer: RTL and testbench

Memory-mapped 32-bit interval timer with a prescaler that raises a level interrupt. The interrupt drives one bit of the interrupt controller's `interrupt_i` vector. The timer sits on the same peripheral bus as the controller and uses the same chip-select/word-address/byte-mask protocol. It supports one-shot and periodic modes and provides a write-1-to-clear (W1C) pending flag.

---
 rtl/interval_timer.sv | 139 +++++++++++++
 tb/tb_interval_timer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
// Memory-mapped 32-bit interval timer: prescaled tick, one-shot or periodic compare,
// W1C pending flag and a registered level interrupt (pending && irq_en).
module interval_timer #(
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic        interrupt_o,
   input  logic        chip_select_i,
   input  logic [3:0]  addr_i,
   input  logic        read_enable_i,
   output logic [31:0] read_data_o,
   input  logic [31:0] write_data_i,
   input  logic [3:0]  write_mask_i
);

   localparam logic [3:0] ADDR_CTRL     = 4'd0;
   localparam logic [3:0] ADDR_PRESCALE = 4'd1;
   localparam logic [3:0] ADDR_COUNT    = 4'd2;
   localparam logic [3:0] ADDR_COMPARE  = 4'd3;
   localparam logic [3:0] ADDR_STATUS   = 4'd4;

   logic                      enable;
   logic                      periodic;
   logic                      irq_en;
   logic                      pending;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic [PRESCALE_WIDTH-1:0] pre;
   logic [31:0]               count;
   logic [31:0]               compare;

   logic                      write;
   logic                      read;
   logic                      wr_ctrl;
   logic                      wr_prescale;
   logic                      wr_count;
   logic                      wr_compare;
   logic                      wr_status;
   logic                      tick;
   logic                      match;
   logic                      enable_next;
   logic [31:0]               count_tick;
   logic [31:0]               rdata;
   logic [PRESCALE_WIDTH-1:0] prescale_merged;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  mask);
      logic [31:0] result;
      result = old;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) result[8*i +: 8] = data[8*i +: 8];
      end
      return result;
   endfunction

   assign write       = chip_select_i && (write_mask_i != 4'b0000);
   assign read        = chip_select_i && read_enable_i;
   assign wr_ctrl     = write && (addr_i == ADDR_CTRL);
   assign wr_prescale = write && (addr_i == ADDR_PRESCALE);
   assign wr_count    = write && (addr_i == ADDR_COUNT);
   assign wr_compare  = write && (addr_i == ADDR_COMPARE);
   assign wr_status   = write && (addr_i == ADDR_STATUS);

   assign tick  = enable && (pre == prescale);
   assign match = tick && (count == compare);

   always_comb begin
      prescale_merged = prescale;
      for (int b = 0; b < PRESCALE_WIDTH; b++) begin
         if (write_mask_i[b/8]) prescale_merged[b] = write_data_i[b];
      end
   end

   // A written enable bit overrides the one-shot self-disable on the same edge.
   always_comb begin
      enable_next = enable;
      if (match && !periodic) enable_next = 1'b0;
      if (wr_ctrl && write_mask_i[0]) enable_next = write_data_i[0];
   end

   always_comb begin
      count_tick = count;
      if (tick) begin
         if (match) count_tick = periodic ? 32'd0 : count;
         else       count_tick = count + 32'd1;
      end
   end

   always_comb begin
      rdata = 32'd0;
      case (addr_i)
         ADDR_CTRL:     rdata = {29'd0, irq_en, periodic, enable};
         ADDR_PRESCALE: rdata = 32'(prescale);
         ADDR_COUNT:    rdata = count;
         ADDR_COMPARE:  rdata = compare;
         ADDR_STATUS:   rdata = {31'd0, pending};
         default:       rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         enable      <= 1'b0;
         periodic    <= 1'b0;
         irq_en      <= 1'b0;
         pending     <= 1'b0;
         prescale    <= '0;
         pre         <= '0;
         count       <= 32'd0;
         compare     <= 32'd0;
         read_data_o <= 32'd0;
         interrupt_o <= 1'b0;
      end else begin
         enable <= enable_next;
         if (wr_ctrl && write_mask_i[0]) begin
            periodic <= write_data_i[1];
            irq_en   <= write_data_i[2];
         end

         if (wr_prescale) prescale <= prescale_merged;

         if (wr_prescale || (wr_ctrl && !enable_next)) pre <= '0;
         else if (enable) pre <= tick ? '0 : pre + PRESCALE_WIDTH'(1);

         // Written COUNT bytes win; unwritten bytes keep the tick result.
         count <= wr_count ? merge_bytes(count_tick, write_data_i, write_mask_i) : count_tick;

         if (wr_compare) compare <= merge_bytes(compare, write_data_i, write_mask_i);

         if (match) pending <= 1'b1;
         else if (wr_status && write_mask_i[0] && write_data_i[0]) pending <= 1'b0;

         if (read) read_data_o <= rdata;
         interrupt_o <= pending && irq_en;
      end
   end

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: directed scenarios plus randomized bus traffic
// compared against a behavioural register-level model.
`timescale 1ns/1ps
module tb_interval_timer;

   localparam int          PW      = 16;
   localparam int unsigned PW_MASK = 32'hFFFF_FFFF >> (32 - PW);

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        interrupt_o;
   logic        chip_select_i;
   logic [3:0]  addr_i;
   logic        read_enable_i;
   logic [31:0] read_data_o;
   logic [31:0] write_data_i;
   logic [3:0]  write_mask_i;

   int checks = 0;
   int passes = 0;

   interval_timer #(.PRESCALE_WIDTH(PW)) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .interrupt_o   (interrupt_o),
      .chip_select_i (chip_select_i),
      .addr_i        (addr_i),
      .read_enable_i (read_enable_i),
      .read_data_o   (read_data_o),
      .write_data_i  (write_data_i),
      .write_mask_i  (write_mask_i)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: register file view of the timer.
   bit          m_en, m_per, m_ie, m_pend, m_irq;
   int unsigned m_div, m_pre, m_cnt, m_cmp, m_rd;
   bit          n_en, n_per, n_ie, n_pend, n_irq;
   int unsigned n_div, n_pre, n_cnt, n_cmp, n_rd;

   function automatic int unsigned merge(input int unsigned old, input int unsigned data,
                                         input int unsigned mask);
      int unsigned r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) begin
            r = r & ~(32'hFF << (8 * i));
            r = r | (data & (32'hFF << (8 * i)));
         end
      end
      return r;
   endfunction

   function automatic int unsigned reg_read(input int unsigned a);
      case (a)
         0: return {29'd0, m_ie, m_per, m_en};
         1: return m_div;
         2: return m_cnt;
         3: return m_cmp;
         4: return {31'd0, m_pend};
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_en = 0; m_per = 0; m_ie = 0; m_pend = 0; m_irq = 0;
      m_div = 0; m_pre = 0; m_cnt = 0; m_cmp = 0; m_rd = 0;
   endtask

   task automatic model_eval();
      bit          wr, tick, hit;
      int unsigned a, d, m;
      a = addr_i; d = write_data_i; m = write_mask_i;
      wr   = chip_select_i && (m != 0);
      tick = m_en && (m_pre == m_div);
      hit  = tick && (m_cnt == m_cmp);
      n_en = m_en; n_per = m_per; n_ie = m_ie; n_pend = m_pend;
      n_div = m_div; n_pre = m_pre; n_cnt = m_cnt; n_cmp = m_cmp; n_rd = m_rd;
      if (chip_select_i && read_enable_i) n_rd = reg_read(a);
      n_irq = m_pend && m_ie;
      if (m_en) n_pre = tick ? 0 : m_pre + 1;
      if (tick) begin
         if (hit) begin
            n_pend = 1;
            if (m_per) n_cnt = 0;
            else       n_en = 0;
         end else begin
            n_cnt = m_cnt + 1;
         end
      end
      if (wr) begin
         case (a)
            0: begin
               if (m[0]) begin
                  n_en = d[0]; n_per = d[1]; n_ie = d[2];
               end
               if (!n_en) n_pre = 0;
            end
            1: begin
               n_div = merge(m_div, d, m) & PW_MASK;
               n_pre = 0;
            end
            2: n_cnt = merge(n_cnt, d, m);
            3: n_cmp = merge(m_cmp, d, m);
            4: if (m[0] && d[0] && !hit) n_pend = 0;
            default: ;
         endcase
      end
   endtask

   task automatic step();
      model_eval();
      @(posedge clk_i);
      #1;
      m_en = n_en; m_per = n_per; m_ie = n_ie; m_pend = n_pend; m_irq = n_irq;
      m_div = n_div; m_pre = n_pre; m_cnt = n_cnt; m_cmp = n_cmp; m_rd = n_rd;
   endtask

   task automatic drive(input bit cs, input bit re, input int unsigned a,
                        input int unsigned d, input int unsigned m);
      chip_select_i = cs;
      read_enable_i = re;
      addr_i        = a[3:0];
      write_data_i  = d;
      write_mask_i  = m[3:0];
   endtask

   task automatic idle_bus();
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic wr(input int unsigned a, input int unsigned d, input int unsigned m);
      drive(1, 0, a, d, m);
      step();
      idle_bus();
   endtask

   task automatic rd(input int unsigned a, output logic [31:0] v);
      drive(1, 1, a, 0, 0);
      step();
      v = read_data_o;
      idle_bus();
   endtask

   task automatic do_reset();
      idle_bus();
      reset_i = 1'b1;
      #3;
      reset_i = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      logic [31:0] v;
      do_reset();
      wr(3, 0, 4'hF);
      wr(0, 7, 4'h1);
      step();
      wr(0, 4, 4'h1);
      wr(2, 32'h1234, 4'hF);
      rd(2, v);
      checks++;
      if (v !== 32'h1234) $display("FAIL reset_setup_count: got %h want %h", v, 32'h1234);
      else passes++;
      checks++;
      if (interrupt_o !== 1'b1) $display("FAIL reset_setup_irq: got %b want 1", interrupt_o);
      else passes++;
      reset_i = 1'b1;
      #1;
      checks++;
      if (interrupt_o !== 1'b0) $display("FAIL reset_async_irq: got %b want 0", interrupt_o);
      else passes++;
      checks++;
      if (read_data_o !== 32'd0) $display("FAIL reset_async_rdata: got %h want 0", read_data_o);
      else passes++;
      #2;
      reset_i = 1'b0;
      model_reset();
      for (int a = 0; a < 5; a++) begin
         rd(a, v);
         checks++;
         if (v !== 32'd0) $display("FAIL reset_reg%0d: got %h want 0", a, v);
         else passes++;
      end
   endtask

   task automatic test_periodic();
      int unsigned cnt_exp [1:5];
      cnt_exp = '{0, 1, 2, 3, 0};
      do_reset();
      wr(3, 3, 4'hF);
      drive(1, 0, 0, 7, 4'h1);
      step();                              // edge 0
      drive(1, 1, 2, 0, 0);
      for (int e = 1; e <= 5; e++) begin
         step();
         checks++;
         if (read_data_o !== cnt_exp[e])
            $display("FAIL periodic_count_e%0d: got %h want %h", e - 1, read_data_o, cnt_exp[e]);
         else passes++;
         checks++;
         if (interrupt_o !== (e >= 5))
            $display("FAIL periodic_irq_e%0d: got %b want %b", e, interrupt_o, e >= 5);
         else passes++;
      end
      drive(1, 0, 4, 1, 4'h1);
      step();                              // edge 6: W1C
      idle_bus();
      checks++;
      if (interrupt_o !== 1'b1) $display("FAIL periodic_irq_e6: got %b want 1", interrupt_o);
      else passes++;
      step();
      checks++;
      if (interrupt_o !== 1'b0) $display("FAIL periodic_irq_e7: got %b want 0", interrupt_o);
      else passes++;
      step();
      checks++;
      if (interrupt_o !== 1'b0) $display("FAIL periodic_irq_e8: got %b want 0", interrupt_o);
      else passes++;
      step();
      checks++;
      if (interrupt_o !== 1'b1) $display("FAIL periodic_irq_e9: got %b want 1", interrupt_o);
      else passes++;
   endtask

   task automatic test_oneshot_prescale();
      logic [31:0] v;
      do_reset();
      wr(1, 2, 4'hF);
      wr(3, 1, 4'hF);
      drive(1, 0, 0, 5, 4'h1);
      step();                              // edge 0
      drive(1, 1, 2, 0, 0);
      for (int e = 1; e <= 14; e++) begin
         step();
         checks++;
         if (read_data_o !== ((e - 1 >= 3) ? 32'd1 : 32'd0))
            $display("FAIL oneshot_count_e%0d: got %h want %h", e - 1, read_data_o,
                     (e - 1 >= 3) ? 32'd1 : 32'd0);
         else passes++;
         checks++;
         if (interrupt_o !== (e >= 7))
            $display("FAIL oneshot_irq_e%0d: got %b want %b", e, interrupt_o, e >= 7);
         else passes++;
      end
      idle_bus();
      rd(0, v);
      checks++;
      if (v !== 32'd4) $display("FAIL oneshot_ctrl: got %h want %h", v, 32'd4);
      else passes++;
      rd(4, v);
      checks++;
      if (v !== 32'd1) $display("FAIL oneshot_pending: got %h want 1", v);
      else passes++;
   endtask

   task automatic test_w1c_collision();
      logic [31:0] v;
      do_reset();
      wr(0, 7, 4'h1);                      // edge 0
      step();                              // edge 1: match
      wr(4, 1, 4'h1);                      // edge 2: W1C + match
      checks++;
      if (interrupt_o !== 1'b1) $display("FAIL w1c_irq_e2: got %b want 1", interrupt_o);
      else passes++;
      wr(0, 4, 4'h1);                      // edge 3: disable
      checks++;
      if (interrupt_o !== 1'b1) $display("FAIL w1c_set_wins: got %b want 1", interrupt_o);
      else passes++;
      wr(4, 0, 4'h1);
      wr(4, 32'hFFFF_FF00, 4'hE);
      rd(4, v);
      checks++;
      if (v !== 32'd1) $display("FAIL w1c_noop_writes: got %h want 1", v);
      else passes++;
      wr(4, 1, 4'h1);
      checks++;
      if (interrupt_o !== 1'b1) $display("FAIL w1c_irq_same: got %b want 1", interrupt_o);
      else passes++;
      step();
      checks++;
      if (interrupt_o !== 1'b0) $display("FAIL w1c_irq_drop: got %b want 0", interrupt_o);
      else passes++;
      rd(4, v);
      checks++;
      if (v !== 32'd0) $display("FAIL w1c_cleared: got %h want 0", v);
      else passes++;
   endtask

   task automatic test_count_wrap();
      logic [31:0] v;
      do_reset();
      wr(3, 5, 4'hF);
      wr(2, 32'hFFFF_FFFF, 4'hF);
      wr(0, 1, 4'h1);
      wr(2, 32'hAA, 4'h1);                 // same edge as the wrapping tick
      rd(2, v);
      checks++;
      if (v !== 32'h0000_00AA) $display("FAIL wrap_masked_write: got %h want %h", v, 32'hAA);
      else passes++;
      wr(0, 0, 4'h1);
      rd(4, v);
      checks++;
      if (v !== 32'd0) $display("FAIL wrap_masked_pending: got %h want 0", v);
      else passes++;
      do_reset();
      wr(3, 5, 4'hF);
      wr(2, 32'hFFFF_FFFF, 4'hF);
      wr(0, 1, 4'h1);
      rd(2, v);
      checks++;
      if (v !== 32'hFFFF_FFFF) $display("FAIL wrap_before: got %h want %h", v, 32'hFFFF_FFFF);
      else passes++;
      rd(2, v);
      checks++;
      if (v !== 32'd0) $display("FAIL wrap_to_zero: got %h want 0", v);
      else passes++;
      rd(4, v);
      checks++;
      if (v !== 32'd0) $display("FAIL wrap_no_flag: got %h want 0", v);
      else passes++;
   endtask

   task automatic test_bus_reads();
      logic [31:0] v;
      do_reset();
      wr(3, 32'h1122_3344, 4'hF);
      rd(7, v);
      checks++;
      if (v !== 32'd0) $display("FAIL read_addr7: got %h want 0", v);
      else passes++;
      drive(1, 1, 3, 32'h5566_7788, 4'hF);
      step();
      idle_bus();
      checks++;
      if (read_data_o !== 32'h1122_3344)
         $display("FAIL read_during_write: got %h want %h", read_data_o, 32'h1122_3344);
      else passes++;
      rd(3, v);
      checks++;
      if (v !== 32'h5566_7788) $display("FAIL read_after_write: got %h want %h", v, 32'h5566_7788);
      else passes++;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (read_data_o !== 32'h5566_7788)
            $display("FAIL read_hold_%0d: got %h want %h", i, read_data_o, 32'h5566_7788);
         else passes++;
      end
      wr(3, 32'hAABB_CCDD, 4'b0110);
      rd(3, v);
      checks++;
      if (v !== 32'h55BB_CC88) $display("FAIL compare_bytes: got %h want %h", v, 32'h55BB_CC88);
      else passes++;
      wr(0, 32'hFFFF_FFF8, 4'hF);
      rd(0, v);
      checks++;
      if (v !== 32'd0) $display("FAIL ctrl_high_bits: got %h want 0", v);
      else passes++;
      wr(1, 32'hFFFF_1234, 4'hF);
      rd(1, v);
      checks++;
      if (v !== 32'h1234) $display("FAIL prescale_width: got %h want %h", v, 32'h1234);
      else passes++;
      wr(15, 32'hFFFF_FFFF, 4'hF);
      rd(15, v);
      checks++;
      if (v !== 32'd0) $display("FAIL read_addr15: got %h want 0", v);
      else passes++;
   endtask

   task automatic test_random();
      int unsigned op, a, d, m;
      bit          re;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         op = $urandom_range(0, 9);
         if (op <= 3) begin
            idle_bus();
         end else if (op <= 5) begin
            drive(1, 1, $urandom_range(0, 7), 0, 0);
         end else begin
            a  = $urandom_range(0, 5);
            if (a == 5) a = 9;
            re = ($urandom_range(0, 3) == 0);
            m  = ($urandom_range(0, 1) == 1) ? 4'hF : $urandom_range(1, 15);
            case (a)
               0: d = ($urandom & 32'hFFFF_FFF8) | $urandom_range(0, 7);
               1: d = $urandom_range(0, 3);
               2: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD + $urandom_range(0, 2)
                                                   : $urandom_range(0, 6);
               3: d = $urandom_range(0, 6);
               default: d = $urandom;
            endcase
            drive(1, re, a, d, m);
         end
         step();
         checks++;
         if (read_data_o !== m_rd)
            $display("FAIL random_rdata_c%0d: got %h want %h", c, read_data_o, m_rd);
         else passes++;
         checks++;
         if (interrupt_o !== m_irq)
            $display("FAIL random_irq_c%0d: got %b want %b", c, interrupt_o, m_irq);
         else passes++;
      end
      idle_bus();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1;
      idle_bus();
      model_reset();
      #2;
      test_reset();
      test_periodic();
      test_oneshot_prescale();
      test_w1c_collision();
      test_count_wrap();
      test_bus_reads();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
